// File: rtl/lutram_fifo_if.sv
// Handshake and status bundle between a lutram_fifo and its producer/consumer logic.
interface lutram_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             rd_en;
  logic             clear_flags;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_data, wr_en, rd_en, clear_flags,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en, clear_flags,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/lutram_fifo_lutram_dp.sv
// Dual-port distributed RAM: synchronous write, asynchronous read, no reset on contents.
module lutram_dp #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO on distributed RAM with occupancy, threshold and sticky error flags.
module lutram_fifo #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ALMOST_FULL  = DEPTH - 2,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic         clk,
  input  logic         reset,
  lutram_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the head slot in the same edge, so a full FIFO can still accept a push.
  assign push_ok = bus.wr_en && (!full || bus.rd_en);
  assign pop_ok  = bus.rd_en && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp    <= wp + AW'(push_ok);
      rp    <= rp + AW'(pop_ok);
      count <= count + CW'(push_ok) - CW'(pop_ok);
      // Error on the same cycle as a clear wins, so no event is lost.
      if (bus.wr_en && !push_ok)  overflow <= 1'b1;
      else if (bus.clear_flags)   overflow <= 1'b0;
      if (bus.rd_en && !pop_ok)   underflow <= 1'b1;
      else if (bus.clear_flags)   underflow <= 1'b0;
    end
  end

  lutram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok && !reset),
    .waddr (wp),
    .wdata (bus.wr_data),
    .raddr (rp),
    .rdata (bus.rd_data)
  );

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CW'(ALMOST_FULL));
  assign bus.almost_empty = (count <= CW'(ALMOST_EMPTY));
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule

// File: tb/tb_lutram_fifo.sv
// Randomised and directed checking of lutram_fifo against a queue-based reference model.
module tb_lutram_fifo;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lutram_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lutram_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  bit m_ovf = 0;
  bit m_unf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update: the FIFO is a queue; errors are rejected requests.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      bit was_full, was_empty, do_pop, do_push;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      do_pop    = bus.rd_en && !was_empty;
      do_push   = bus.wr_en && (!was_full || bus.rd_en);
      if (bus.wr_en && !do_push) m_ovf = 1;
      else if (bus.clear_flags)  m_ovf = 0;
      if (bus.rd_en && !do_pop)  m_unf = 1;
      else if (bus.clear_flags)  m_unf = 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(bus.wr_data);
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(bus.count), 32'(q.size()));
      chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("empty", 32'(bus.empty), 32'(q.size() == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(q.size() >= DEPTH - 2));
      chk("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= 2));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
      chk("full_and_empty", 32'(bus.full && bus.empty), 32'd0);
      chk("count_le_depth", 32'(bus.count <= DEPTH), 32'd1);
      if (q.size() > 0) chk("rd_data", 32'(bus.rd_data), 32'(q[0]));
    end
  end

  task automatic cycle(input bit wr, input bit rd, input logic [WIDTH-1:0] d,
                       input bit clr, input bit rst);
    bus.wr_en       = wr;
    bus.rd_en       = rd;
    bus.wr_data     = d;
    bus.clear_flags = clr;
    reset           = rst;
    @(posedge clk);
    #1;
    bus.wr_en       = 0;
    bus.rd_en       = 0;
    bus.clear_flags = 0;
    reset           = 0;
  endtask

  initial begin
    int nw, nr;
    bus.wr_en = 0; bus.rd_en = 0; bus.wr_data = '0; bus.clear_flags = 0; reset = 1;
    cycle(0, 0, 8'h00, 0, 1);
    started = 1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    chk("rst_almost_full", 32'(bus.almost_full), 32'd0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 8'(i), 0, 0);
      if (i == 12) chk("af_at_13", 32'(bus.almost_full), 32'd0);
      if (i == 13) chk("af_at_14", 32'(bus.almost_full), 32'd1);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(bus.rd_data), 32'(i));
      cycle(0, 1, 8'h00, 0, 0);
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Overflow on a full FIFO, original data survives
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), 0, 0);
    cycle(1, 0, 8'hAA, 0, 0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_data", 32'(bus.rd_data), 32'(i));
      cycle(0, 1, 8'h00, 0, 0);
    end

    // Push+pop while full: 0xBB lands in the freed slot and emerges last
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), 0, 0);
    cycle(1, 1, 8'hBB, 0, 0);
    chk("full_pp_count", 32'(bus.count), 32'd16);
    for (int i = 1; i < 17; i++) begin
      chk("full_pp_data", 32'(bus.rd_data), (i == 16) ? 32'hBB : 32'(i));
      cycle(0, 1, 8'h00, 0, 0);
    end

    // Empty push+pop: push taken, pop rejected
    cycle(0, 0, 8'h00, 1, 0);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    cycle(1, 1, 8'h55, 0, 0);
    chk("emp_pp_count", 32'(bus.count), 32'd1);
    chk("emp_pp_unf", 32'(bus.underflow), 32'd1);
    chk("emp_pp_data", 32'(bus.rd_data), 32'h55);
    cycle(0, 1, 8'h00, 0, 0);

    // Pointer wrap with count oscillating 0..3
    nw = 0; nr = 0;
    for (int i = 0; i < 40; i++) begin
      if (((i / 3) % 2) == 0) begin
        cycle(1, 0, 8'(nw + 8'h40), 0, 0);
        nw++;
      end else begin
        chk("wrap_data", 32'(bus.rd_data), 32'(8'(nr + 8'h40)));
        cycle(0, 1, 8'h00, 0, 0);
        nr++;
      end
    end
    chk("wrap_count", 32'(bus.count), 32'(nw - nr));
    cycle(0, 0, 8'h00, 1, 0);
    chk("clr_unf", 32'(bus.underflow), 32'd0);
    while (!bus.empty && nr < nw) begin
      cycle(0, 1, 8'h00, 0, 0);
      nr++;
    end

    // Reset mid-stream with a push pending
    for (int i = 0; i < 7; i++) cycle(1, 0, 8'(i + 8'h70), 0, 0);
    chk("pre_rst_count", 32'(bus.count), 32'd7);
    cycle(1, 0, 8'hEE, 0, 1);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    cycle(1, 0, 8'h3C, 0, 0);
    chk("post_rst_data", 32'(bus.rd_data), 32'h3C);
    cycle(0, 1, 8'h00, 0, 0);

    // Random traffic with drifting push/pop bias
    for (int i = 0; i < 10000; i++) begin
      int unsigned bias;
      bias = ((i / 500) % 3 == 0) ? 30 : (((i / 500) % 3 == 1) ? 70 : 50);
      cycle($urandom_range(0, 99) < bias ? 1'b0 : 1'b1,
            $urandom_range(0, 99) < (100 - bias) ? 1'b0 : 1'b1,
            8'($urandom),
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 999) == 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
